hack_mem_arbiter: RTL
=====================

Name: hack_mem_arbiter

Overview:
- Parametrised N-channel arbiter that shares one spi_sram_encoder instance among several requesters.
- Typical requesters: CPU data port, ROM stream loader, future VRAM scanout and DMA.
- Generalises the fixed two-way loader/CPU ROM mux to NUM_CH channels, with selectable round-robin or fixed priority, per-channel completion acknowledge and a start timeout.
- Sits between requesters and the encoder's request/busy/initialized interface.

Parameters:
- NUM_CH, 3: number of requester channels (2..8).
- ADDRESS_WIDTH, 16: channel and encoder address width.
- WORD_WIDTH, 16: data width.
- RR_MODE, 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
- START_TIMEOUT, 15: maximum cycles to wait for mem_busy to rise after issue.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ch_req  in  NUM_CH  per-channel request level; held until that channel's ack.
- ch_we  in  NUM_CH  per-channel write enable.
- ch_addr  in  NUM_CH*ADDRESS_WIDTH  packed addresses; channel i occupies bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- ch_wdata  in  NUM_CH*WORD_WIDTH  packed write data.
- ch_ack  out  NUM_CH  one-cycle completion pulse, one-hot.
- ch_err  out  NUM_CH  one-cycle timeout pulse, one-hot.
- ch_rdata  out  WORD_WIDTH  read data of the last completed read; valid when ack pulses.
- ch_grant  out  NUM_CH  one-hot owner of the current transaction.
- mem_request  out  1  one-cycle start strobe to the encoder.
- mem_address  out  ADDRESS_WIDTH  latched address.
- mem_write_enable  out  1  latched write enable.
- mem_wdata  out  WORD_WIDTH  latched write data; connects to the encoder's data_out.
- mem_rdata  in  WORD_WIDTH  encoder read data; connects to the encoder's data_in.
- mem_busy  in  1  encoder busy.
- mem_initialized  in  1  encoder init complete.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr = NUM_CH-1, timeout counter 0. Reset mid-transaction abandons it with no ack or err; the encoder is reset by the same signal.
- IDLE:
  - If mem_initialized && !mem_busy && |ch_req: select the winner, latch its addr/we/wdata into the mem_* registers, set ch_grant, go to ISSUE.
  - Otherwise stay in IDLE.
  - No grant while !mem_initialized.
- Winner selection:
  - RR_MODE=1: first requesting index scanning upward from rr_ptr+1 modulo NUM_CH.
  - RR_MODE=0: lowest requesting index.
- ISSUE: mem_request=1 for exactly one cycle, clear the counter, go to WAIT_START.
- WAIT_START:
  - mem_busy=1: go to WAIT_DONE.
  - Counter reaches START_TIMEOUT with busy still 0: pulse ch_err for the owner, clear ch_grant, go to IDLE. rr_ptr still advances to the owner.
- WAIT_DONE: on mem_busy=0:
  - Capture mem_rdata into ch_rdata (reads only; writes leave ch_rdata unchanged).
  - Pulse ch_ack for the owner.
  - rr_ptr <= owner index; clear ch_grant; go to IDLE.
- Minimum turnaround: ack-to-next-ISSUE is 1 cycle (IDLE evaluates on the cycle after ack). Back-to-back requests therefore cost busy duration + 3 cycles.
- Channel contract: the requester must drop or re-present ch_req on the cycle after its ack. A request still high after ack is a new transaction.
- ch_req dropped while granted: the transaction completes normally and ack still pulses.
- ch_addr/ch_we/ch_wdata may change after grant; the latched values are used.
- Simultaneous requests with RR_MODE=1: a channel waits at most NUM_CH-1 transactions (no starvation). Fixed mode may starve high indices; that is documented and intended.
- Assertions:
  - ch_grant, ch_ack and ch_err are each $onehot0.
  - mem_request implies the state was ISSUE.
  - ack and err are never both high.

Decomposition:
- Shared package/include (params.v style): state encodings IDLE/ISSUE/WAIT_START/WAIT_DONE, and defaults for ADDRESS_WIDTH/WORD_WIDTH taken from the existing ROM/RAM width constants.
- One sub-module, hack_rr_picker: combinational rotate-priority encoder (req, ptr, mode -> one-hot grant + index). Reusable for a future interrupt controller.

Test Plan:
- Init gate: mem_initialized=0, ch_req=3'b111 for 20 cycles -> no mem_request. Raise init -> ch0 granted first (rr_ptr=2 wraps to 0).
- Round-robin: all three channels hold requests, BFM busy 6 cycles -> grant order 0,1,2,0,1. Each ack is one cycle; mem_address matches the granting channel's ch_addr.
- Fixed mode: RR_MODE=0, ch_req=3'b110 continuous -> ch1 wins every transaction, ch2 never granted.
- Read data: ch1 reads addr 16'h4000, BFM returns 16'hBEEF -> ch_rdata=16'hBEEF on ch_ack[1]. A following write from ch0 leaves ch_rdata=16'hBEEF.
- Timeout: BFM ignores the request -> ch_err[owner] pulses exactly START_TIMEOUT+1 cycles after mem_request, no ack. Next request proceeds normally.
- Reset mid-op: assert reset in WAIT_DONE -> next cycle all outputs 0, no ack. After release, pending requests are served starting from ch0.

Source files
------------

// File: rtl/hack_mem_arbiter_pkg.sv
// Shared definitions for the hack memory arbiter.
// - Arbiter FSM state encoding.
// - Default address/data widths, matching the existing ROM/RAM width constants.
package hack_mem_arbiter_pkg;

  localparam int ROM_ADDRESS_WIDTH = 16;
  localparam int RAM_WORD_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/hack_rr_picker.sv
// Combinational rotate-priority encoder.
// Picks one requester, either scanning upward from i_ptr+1 (wrapping) in
// rotate mode, or the lowest requesting index in fixed mode.
// Ports:
//   i_req     - request vector, one bit per requester
//   i_ptr     - index of the most recently served requester (rotate mode)
//   i_rr_mode - 1 = rotate priority, 0 = fixed priority (lowest wins)
//   o_grant   - one-hot winner, all zero when nothing requests
//   o_idx     - binary index of the winner
//   o_valid   - at least one requester present
module hack_rr_picker #(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0]         i_req,
  input  logic [$clog2(NUM_CH)-1:0] i_ptr,
  input  logic                      i_rr_mode,
  output logic [NUM_CH-1:0]         o_grant,
  output logic [$clog2(NUM_CH)-1:0] o_idx,
  output logic                      o_valid
);

  localparam int IDX_W = $clog2(NUM_CH);
  // One extra bit so ptr+1+k (at most 2*NUM_CH-1) fits before wrapping.
  localparam int CAND_W = IDX_W + 1;

  logic [CAND_W-1:0] w_cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch to hold it.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_rr_mode) begin
        w_cand = {1'b0, i_ptr} + CAND_W'(k) + CAND_W'(1);
        // A single subtraction suffices since w_cand < 2*NUM_CH.
        if (w_cand >= CAND_W'(NUM_CH)) begin
          w_cand = w_cand - CAND_W'(NUM_CH);
        end
      end else begin
        w_cand = CAND_W'(k);
      end
      if (!o_valid && i_req[w_cand[IDX_W-1:0]]) begin
        o_valid                  = 1'b1;
        o_idx                    = w_cand[IDX_W-1:0];
        o_grant[w_cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hack_mem_arbiter.sv
// N-channel arbiter sharing one spi_sram_encoder among several requesters.
// One transaction at a time: IDLE picks a winner and latches its request,
// ISSUE strobes mem_request, WAIT_START waits (bounded) for mem_busy to rise,
// WAIT_DONE waits for mem_busy to fall and acknowledges the owner.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   ch_req/we/addr/wdata - per-channel request, packed NUM_CH-wide
//   ch_ack, ch_err       - one-cycle one-hot completion / timeout pulses
//   ch_rdata             - read data of the last completed read
//   ch_grant             - one-hot owner of the current transaction
//   mem_request          - one-cycle start strobe to the encoder
//   mem_address/write_enable/wdata - latched request towards the encoder
//   mem_rdata, mem_busy, mem_initialized - encoder read data and status
module hack_mem_arbiter
  import hack_mem_arbiter_pkg::*;
#(
  parameter int NUM_CH        = 3,
  parameter int ADDRESS_WIDTH = ROM_ADDRESS_WIDTH,
  parameter int WORD_WIDTH    = RAM_WORD_WIDTH,
  parameter int RR_MODE       = 1,
  parameter int START_TIMEOUT = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               ch_req,
  input  logic [NUM_CH-1:0]               ch_we,
  input  logic [NUM_CH*ADDRESS_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*WORD_WIDTH-1:0]    ch_wdata,
  output logic [NUM_CH-1:0]               ch_ack,
  output logic [NUM_CH-1:0]               ch_err,
  output logic [WORD_WIDTH-1:0]           ch_rdata,
  output logic [NUM_CH-1:0]               ch_grant,
  output logic                            mem_request,
  output logic [ADDRESS_WIDTH-1:0]        mem_address,
  output logic                            mem_write_enable,
  output logic [WORD_WIDTH-1:0]           mem_wdata,
  input  logic [WORD_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_busy,
  input  logic                            mem_initialized
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  arb_state_e                r_state, w_state_nxt;
  logic [IDX_W-1:0]          r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]          r_owner, w_owner_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [NUM_CH-1:0]         r_grant, w_grant_nxt;
  logic [NUM_CH-1:0]         r_ack, w_ack_nxt;
  logic [NUM_CH-1:0]         r_err, w_err_nxt;
  logic [WORD_WIDTH-1:0]     r_rdata, w_rdata_nxt;
  logic [ADDRESS_WIDTH-1:0]  r_addr, w_addr_nxt;
  logic                      r_we, w_we_nxt;
  logic [WORD_WIDTH-1:0]     r_wdata, w_wdata_nxt;

  logic [NUM_CH-1:0]         w_pick_grant;
  logic [IDX_W-1:0]          w_pick_idx;
  logic                      w_pick_valid;

  hack_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .i_req     (ch_req),
    .i_ptr     (r_ptr),
    .i_rr_mode (RR_MODE != 0),
    .o_grant   (w_pick_grant),
    .o_idx     (w_pick_idx),
    .o_valid   (w_pick_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_ack_nxt   = '0;
    w_err_nxt   = '0;
    w_rdata_nxt = r_rdata;
    w_addr_nxt  = r_addr;
    w_we_nxt    = r_we;
    w_wdata_nxt = r_wdata;
    unique case (r_state)
      IDLE: begin
        if (mem_initialized && !mem_busy && w_pick_valid) begin
          w_state_nxt = ISSUE;
          w_owner_nxt = w_pick_idx;
          w_grant_nxt = w_pick_grant;
          w_addr_nxt  = ch_addr[int'(w_pick_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          w_we_nxt    = ch_we[w_pick_idx];
          w_wdata_nxt = ch_wdata[int'(w_pick_idx)*WORD_WIDTH +: WORD_WIDTH];
        end
      end
      ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (mem_busy) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
          // START_TIMEOUT samples of busy=0 seen: give up on this owner.
          w_err_nxt   = r_grant;
          w_ptr_nxt   = r_owner;
          w_grant_nxt = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!mem_busy) begin
          w_ack_nxt = r_grant;
          if (!r_we) begin
            w_rdata_nxt = mem_rdata;
          end
          w_ptr_nxt   = r_owner;
          w_grant_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= IDX_W'(NUM_CH - 1);
      r_owner <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_ack   <= '0;
      r_err   <= '0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      r_addr  <= w_addr_nxt;
      r_we    <= w_we_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  assign ch_grant         = r_grant;
  assign ch_ack           = r_ack;
  assign ch_err           = r_err;
  assign ch_rdata         = r_rdata;
  assign mem_request      = (r_state == ISSUE);
  assign mem_address      = r_addr;
  assign mem_write_enable = r_we;
  assign mem_wdata        = r_wdata;

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(ch_grant));
  a_ack_onehot:   assert property (@(posedge clk) disable iff (reset) $onehot0(ch_ack));
  a_err_onehot:   assert property (@(posedge clk) disable iff (reset) $onehot0(ch_err));
  a_req_issue:    assert property (@(posedge clk) disable iff (reset) mem_request |-> r_state == ISSUE);
  a_ack_not_err:  assert property (@(posedge clk) disable iff (reset) !(|ch_ack && |ch_err));

endmodule
